// File: rtl/inv_mix_columns_sequencer_if.sv
// Valid/ready handshake bundle for the inverse MixColumns sequencer.
// The slave side is the sequencer; the master side feeds states and drains results.
interface inv_mix_columns_sequencer_if;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_state;
    logic         bypass;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_state;

    modport slave (
        input  in_valid, in_state, bypass, out_ready,
        output in_ready, out_valid, out_state
    );

    modport master (
        output in_valid, in_state, bypass, out_ready,
        input  in_ready, out_valid, out_state
    );
endinterface

// File: rtl/inv_mix_columns_sequencer.sv
// Applies InvMixColumns to a 128-bit AES state one column per clock through a single
// shared combinational column multiplier; optional per-block bypass for the final round.
module inv_mix_columns_sequencer #(
    parameter bit BYPASS_EN = 1'b1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    inv_mix_columns_sequencer_if.slave    bus,
    output logic                          busy_o
);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e       state_q, state_d;
    logic [1:0]   col_q, col_d;
    logic [127:0] src_q, src_d;
    logic [127:0] res_q, res_d;
    logic         byp_q, byp_d;
    logic [31:0]  col_in;
    logic [31:0]  col_out;

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] inv_col(input logic [31:0] c);
        logic [7:0] a [4];
        logic [7:0] m9 [4];
        logic [7:0] mb [4];
        logic [7:0] md [4];
        logic [7:0] me [4];
        logic [7:0] x2, x4, x8;
        for (int i = 0; i < 4; i++) begin
            a[i]  = c[31-8*i -: 8];
            x2    = xt(a[i]);
            x4    = xt(x2);
            x8    = xt(x4);
            m9[i] = x8 ^ a[i];
            mb[i] = x8 ^ x2 ^ a[i];
            md[i] = x8 ^ x4 ^ a[i];
            me[i] = x8 ^ x4 ^ x2;
        end
        return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
                m9[0] ^ me[1] ^ mb[2] ^ md[3],
                md[0] ^ m9[1] ^ me[2] ^ mb[3],
                mb[0] ^ md[1] ^ m9[2] ^ me[3]};
    endfunction

    always_comb begin
        col_in = src_q[127:96];
        unique case (col_q)
            2'd0: col_in = src_q[127:96];
            2'd1: col_in = src_q[95:64];
            2'd2: col_in = src_q[63:32];
            2'd3: col_in = src_q[31:0];
        endcase
    end

    assign col_out = inv_col(col_in);

    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        src_d   = src_q;
        res_d   = res_q;
        byp_d   = byp_q;
        unique case (state_q)
            StIdle: begin
                if (bus.in_valid) begin
                    src_d   = bus.in_state;
                    byp_d   = bus.bypass & BYPASS_EN;
                    col_d   = 2'd0;
                    state_d = StRun;
                    if (byp_d) res_d = bus.in_state;
                end
            end
            StRun: begin
                // A bypassed block spends one RUN cycle with no column writes.
                if (byp_q) begin
                    state_d = StDone;
                end else begin
                    unique case (col_q)
                        2'd0: res_d[127:96] = col_out;
                        2'd1: res_d[95:64]  = col_out;
                        2'd2: res_d[63:32]  = col_out;
                        2'd3: res_d[31:0]   = col_out;
                    endcase
                    col_d = col_q + 2'd1;
                    if (col_q == 2'd3) state_d = StDone;
                end
            end
            StDone: begin
                if (bus.out_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            col_q   <= 2'd0;
            src_q   <= '0;
            res_q   <= '0;
            byp_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            src_q   <= src_d;
            res_q   <= res_d;
            byp_q   <= byp_d;
        end
    end

    assign bus.in_ready  = (state_q == StIdle);
    assign bus.out_valid = (state_q == StDone);
    assign bus.out_state = res_q;
    assign busy_o        = (state_q != StIdle);

endmodule

// File: tb/tb_inv_mix_columns_sequencer.sv
// Directed and randomized checks of the inverse MixColumns sequencer, with and without
// bypass support, against a generic GF(2^8) matrix model.
module tb_inv_mix_columns_sequencer;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic busy_a, busy_b;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    inv_mix_columns_sequencer_if ifa ();
    inv_mix_columns_sequencer_if ifb ();

    inv_mix_columns_sequencer #(.BYPASS_EN(1'b1)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifa),
        .busy_o(busy_a)
    );

    inv_mix_columns_sequencer #(.BYPASS_EN(1'b0)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifb),
        .busy_o(busy_b)
    );

    typedef struct {
        logic [127:0] st;
        logic         byp;
        logic [127:0] exp;
        int           lat;
    } vec_t;

    vec_t vecs[4];

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
        end
        return p;
    endfunction

    // Circulant matrix with first row m0..m3 applied to every column.
    function automatic logic [127:0] mix(input logic [127:0] s, input logic [31:0] row0);
        logic [7:0]   m [4];
        logic [7:0]   a [4];
        logic [7:0]   r;
        logic [127:0] o = '0;
        for (int i = 0; i < 4; i++) m[i] = row0[31-8*i -: 8];
        for (int c = 0; c < 4; c++) begin
            for (int i = 0; i < 4; i++) a[i] = s[127-32*c-8*i -: 8];
            for (int row = 0; row < 4; row++) begin
                r = 8'h00;
                for (int j = 0; j < 4; j++) r = r ^ gmul(m[(j - row) & 3], a[j]);
                o[127-32*c-8*row -: 8] = r;
            end
        end
        return o;
    endfunction

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", name, got, exp);
        end
    endtask

    // Sends one block to DUT a (sel=0) or b (sel=1); returns handshake-to-valid latency.
    task automatic send_block(input bit sel, input logic [127:0] s, input logic b,
                              input int stall, output int lat, output logic [127:0] res);
        int n = 0;
        if (sel) begin ifb.in_state = s; ifb.bypass = b; ifb.in_valid = 1'b1; end
        else     begin ifa.in_state = s; ifa.bypass = b; ifa.in_valid = 1'b1; end
        while (!(sel ? ifb.in_ready : ifa.in_ready) && n < 20) begin
            @(posedge clk); #1; n++;
        end
        if (n >= 20) chk("in_ready_timeout", 128'd0, 128'd1);
        @(posedge clk); #1;
        if (sel) ifb.in_valid = 1'b0; else ifa.in_valid = 1'b0;
        lat = 0;
        while (!(sel ? ifb.out_valid : ifa.out_valid) && lat < 20) begin
            @(posedge clk); #1; lat++;
        end
        repeat (stall) begin @(posedge clk); #1; end
        res = sel ? ifb.out_state : ifa.out_state;
        if (sel) ifb.out_ready = 1'b1; else ifa.out_ready = 1'b1;
        @(posedge clk); #1;
        if (sel) ifb.out_ready = 1'b0; else ifa.out_ready = 1'b0;
    endtask

    logic [127:0] res, data, st, exp_bp;
    logic [127:0] bb_in [8];
    logic [127:0] bb_out [8];
    int           lat, k, got, cyc, last;
    logic         bad, per_ok, spur;

    initial begin
        vecs[0] = '{128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6, 1'b0,
                    128'hdb135345_f20a225c_01010101_c6c6c6c6, 4};
        vecs[1] = '{128'hd5d5d7d6_4d7ebdf8_8e4da1bc_01010101, 1'b0,
                    128'hd4d4d4d5_2d26314c_db135345_01010101, 4};
        vecs[2] = '{128'h00112233_44556677_8899aabb_ccddeeff, 1'b1,
                    128'h00112233_44556677_8899aabb_ccddeeff, 1};
        vecs[3] = '{128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6, 1'b1,
                    128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6, 1};

        ifa.in_valid = 1'b0; ifa.in_state = '0; ifa.bypass = 1'b0; ifa.out_ready = 1'b0;
        ifb.in_valid = 1'b0; ifb.in_state = '0; ifb.bypass = 1'b0; ifb.out_ready = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", {127'd0, ifa.out_valid}, 128'd0);
        chk("rst_in_ready", {127'd0, ifa.in_ready}, 128'd1);
        chk("rst_busy", {127'd0, busy_a}, 128'd0);
        chk("rst_out_state", ifa.out_state, 128'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 4; i++) begin
            send_block(1'b0, vecs[i].st, vecs[i].byp, 0, lat, res);
            chk($sformatf("vec%0d_state", i), res, vecs[i].exp);
            chk($sformatf("vec%0d_latency", i), 128'(lat), 128'(vecs[i].lat));
        end

        // Bypass request ignored when bypass support is compiled out.
        send_block(1'b1, vecs[2].st, 1'b1, 0, lat, res);
        chk("nobyp_state", res, mix(vecs[2].st, 32'h0e0b0d09));
        chk("nobyp_latency", 128'(lat), 128'd4);

        // Backpressure: result held, in_valid ignored while DONE.
        exp_bp = vecs[0].exp;
        ifa.in_state = vecs[0].st; ifa.bypass = 1'b0; ifa.in_valid = 1'b1;
        @(posedge clk); #1;
        ifa.in_valid = 1'b0;
        lat = 0;
        while (!ifa.out_valid && lat < 20) begin @(posedge clk); #1; lat++; end
        bad = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (ifa.out_state !== exp_bp || !ifa.out_valid || ifa.in_ready) bad = 1'b1;
            ifa.in_valid = i[0];
            ifa.in_state = {$urandom, $urandom, $urandom, $urandom};
            @(posedge clk); #1;
        end
        chk("bp_hold", {127'd0, bad}, 128'd0);
        chk("bp_state", ifa.out_state, exp_bp);
        ifa.in_valid = 1'b0;
        ifa.out_ready = 1'b1;
        @(posedge clk); #1;
        ifa.out_ready = 1'b0;
        chk("bp_release_valid", {127'd0, ifa.out_valid}, 128'd0);
        chk("bp_release_ready", {127'd0, ifa.in_ready}, 128'd1);
        spur = 1'b0;
        repeat (6) begin @(posedge clk); #1; if (ifa.out_valid || busy_a) spur = 1'b1; end
        chk("bp_no_extra", {127'd0, spur}, 128'd0);

        // Reset mid-RUN discards the block.
        ifa.in_state = vecs[1].st; ifa.bypass = 1'b0; ifa.in_valid = 1'b1;
        @(posedge clk); #1;
        ifa.in_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("midrun_rst_valid", {127'd0, ifa.out_valid}, 128'd0);
        chk("midrun_rst_ready", {127'd0, ifa.in_ready}, 128'd1);
        chk("midrun_rst_busy", {127'd0, busy_a}, 128'd0);
        chk("midrun_rst_state", ifa.out_state, 128'd0);
        spur = 1'b0;
        repeat (8) begin @(posedge clk); #1; if (ifa.out_valid) spur = 1'b1; end
        chk("midrun_rst_spurious", {127'd0, spur}, 128'd0);

        // Reset coinciding with a handshake latches nothing.
        rst_n = 1'b0;
        ifa.in_state = vecs[2].st; ifa.bypass = 1'b1; ifa.in_valid = 1'b1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        ifa.in_valid = 1'b0;
        chk("rst_hs_busy", {127'd0, busy_a}, 128'd0);
        spur = 1'b0;
        repeat (6) begin @(posedge clk); #1; if (ifa.out_valid) spur = 1'b1; end
        chk("rst_hs_spurious", {127'd0, spur}, 128'd0);
        chk("rst_hs_state", ifa.out_state, 128'd0);

        // Back-to-back: in_valid and out_ready held high.
        for (int i = 0; i < 8; i++) bb_in[i] = {$urandom, $urandom, $urandom, $urandom};
        k = 0; got = 0; cyc = 0; last = -1; per_ok = 1'b1;
        ifa.bypass = 1'b0;
        ifa.out_ready = 1'b1;
        while (got < 8 && cyc < 100) begin
            if (ifa.in_ready) begin
                if (k < 8) begin ifa.in_state = bb_in[k]; ifa.in_valid = 1'b1; k++; end
                else ifa.in_valid = 1'b0;
            end
            if (ifa.out_valid) begin
                bb_out[got] = ifa.out_state;
                if (got > 0 && cyc - last != 6) per_ok = 1'b0;
                last = cyc;
                got++;
            end
            @(posedge clk); #1;
            cyc++;
        end
        ifa.in_valid = 1'b0;
        ifa.out_ready = 1'b0;
        chk("b2b_count", 128'(got), 128'd8);
        chk("b2b_period", {127'd0, per_ok}, 128'd1);
        for (int i = 0; i < got; i++)
            chk($sformatf("b2b_%0d", i), bb_out[i], mix(bb_in[i], 32'h0e0b0d09));
        @(posedge clk); #1;

        // Round trip: inverse of forward MixColumns recovers the data.
        for (int i = 0; i < 1000; i++) begin
            data = {$urandom, $urandom, $urandom, $urandom};
            st = mix(data, 32'h02030101);
            send_block(1'b0, st, 1'b0, int'($urandom_range(0, 3)), lat, res);
            chk($sformatf("roundtrip_%0d", i), res, data);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
